// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_share_arbiter_if                                              |
// | Request A/B, shared response and status bundle for the arbiter.  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              a_valid_i;
  logic              a_ready_o;
  logic [2:0]        a_op_i;
  logic [DATA_W-1:0] a_data1_i;
  logic [DATA_W-1:0] a_data2_i;

  logic              b_valid_i;
  logic              b_ready_o;
  logic [2:0]        b_op_i;
  logic [DATA_W-1:0] b_data1_i;
  logic [DATA_W-1:0] b_data2_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic              rsp_id_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_zero_o;
  logic              rsp_err_o;
  logic              busy_o;

  modport slave (
    input  a_valid_i, a_op_i, a_data1_i, a_data2_i,
    input  b_valid_i, b_op_i, b_data1_i, b_data2_i,
    input  rsp_ready_i,
    output a_ready_o, b_ready_o,
    output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o, rsp_err_o, busy_o
  );

  modport master (
    output a_valid_i, a_op_i, a_data1_i, a_data2_i,
    output b_valid_i, b_op_i, b_data1_i, b_data2_i,
    output rsp_ready_i,
    input  a_ready_o, b_ready_o,
    input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o, rsp_err_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_share_arbiter                                                 |
// | Round-robin sharing of one and/or/add/sub/mul ALU by two callers. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module alu_share_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3   // legal range 1..15
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] c_op_and = 3'b000;
  localparam logic [2:0] c_op_or  = 3'b001;
  localparam logic [2:0] c_op_add = 3'b010;
  localparam logic [2:0] c_op_sub = 3'b011;
  localparam logic [2:0] c_op_mul = 3'b100;
  localparam logic [3:0] c_mul_cnt = 4'(MUL_LAT - 1);

  state_t            r_state;
  logic              r_rr_last;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_d1;
  logic [DATA_W-1:0] r_d2;
  logic              r_id;
  logic [3:0]        r_cnt;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_zero;
  logic              r_rsp_err;

  logic              w_idle;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_accept;
  logic [2:0]        w_sel_op;
  logic [DATA_W-1:0] w_alu;
  logic              w_illegal;

  // On a tie the requester that did not win last time is granted.
  assign w_idle    = (r_state == S_IDLE);
  assign w_grant_a = w_idle && bus.a_valid_i && (!bus.b_valid_i || r_rr_last);
  assign w_grant_b = w_idle && bus.b_valid_i && (!bus.a_valid_i || !r_rr_last);
  assign w_accept  = w_grant_a || w_grant_b;
  assign w_sel_op  = w_grant_b ? bus.b_op_i : bus.a_op_i;

  assign bus.a_ready_o   = w_grant_a;
  assign bus.b_ready_o   = w_grant_b;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_id_o    = r_id;
  assign bus.rsp_data_o  = r_rsp_data;
  assign bus.rsp_zero_o  = r_rsp_zero;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.busy_o      = !w_idle;

  always_comb begin
    w_alu     = '0;
    w_illegal = 1'b0;
    case (r_op)
      c_op_and: w_alu = r_d1 & r_d2;
      c_op_or:  w_alu = r_d1 | r_d2;
      c_op_add: w_alu = r_d1 + r_d2;
      c_op_sub: w_alu = r_d1 - r_d2;
      c_op_mul: w_alu = r_d1 * r_d2;
      default:  w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_rr_last   <= 1'b1;
      r_op        <= '0;
      r_d1        <= '0;
      r_d2        <= '0;
      r_id        <= 1'b0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= w_sel_op;
            r_d1      <= w_grant_b ? bus.b_data1_i : bus.a_data1_i;
            r_d2      <= w_grant_b ? bus.b_data2_i : bus.a_data2_i;
            r_id      <= w_grant_b;
            r_rr_last <= w_grant_b;
            r_cnt     <= (w_sel_op == c_op_mul) ? c_mul_cnt : 4'd0;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_rsp_data  <= w_alu;
            r_rsp_zero  <= (w_alu == '0);
            r_rsp_err   <= w_illegal;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          // Response fields return to zero once consumed.
          if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_alu_share_arbiter                                              |
// | Directed vectors with hand-computed results for the ALU arbiter.  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_alu_share_arbiter;

  localparam logic [2:0] c_and = 3'b000;
  localparam logic [2:0] c_or  = 3'b001;
  localparam logic [2:0] c_add = 3'b010;
  localparam logic [2:0] c_sub = 3'b011;
  localparam logic [2:0] c_mul = 3'b100;
  localparam logic [2:0] c_ill = 3'b111;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_W(32)) bus ();

  alu_share_arbiter #(.DATA_W(32), .MUL_LAT(3)) u_dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input bit side, input bit v, input logic [2:0] op,
                           input logic [31:0] d1, input logic [31:0] d2);
    if (side) begin
      bus.b_valid_i = v; bus.b_op_i = op; bus.b_data1_i = d1; bus.b_data2_i = d2;
    end else begin
      bus.a_valid_i = v; bus.a_op_i = op; bus.a_data1_i = d1; bus.a_data2_i = d2;
    end
  endtask

  // Entered #1 after the accept edge; rsp_ready_i must already be high.
  task automatic expect_rsp(input int lat, input bit id, input logic [31:0] data,
                            input bit zero, input bit err);
    int c = 0;
    bit seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) begin
        seen = 1'b1;
        c = i;
      end else begin
        @(posedge clk);
      end
    end
    check_vec("rsp_latency", c, lat);
    if (seen) begin
      check_vec("rsp_id", bus.rsp_id_o, id);
      check_vec("rsp_data", bus.rsp_data_o, data);
      check_vec("rsp_zero", bus.rsp_zero_o, zero);
      check_vec("rsp_err", bus.rsp_err_o, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input bit side, input logic [2:0] op, input logic [31:0] d1,
                        input logic [31:0] d2, input int lat, input logic [31:0] data,
                        input bit zero, input bit err);
    drive_req(side, 1'b1, op, d1, d2);
    @(negedge clk);
    check_vec("grant", side ? bus.b_ready_o : bus.a_ready_o, 1);
    @(posedge clk); #1;
    drive_req(side, 1'b0, op, d1, d2);
    expect_rsp(lat, side, data, zero, err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_req(1'b0, 1'b0, c_and, 0, 0);
    drive_req(1'b1, 1'b0, c_and, 0, 0);
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check_vec("rst_busy", bus.busy_o, 0);
    check_vec("rst_valid", bus.rsp_valid_o, 0);
    check_vec("rst_data", bus.rsp_data_o, 0);
    check_vec("rst_zero", bus.rsp_zero_o, 0);
    check_vec("rst_err", bus.rsp_err_o, 0);
    check_vec("rst_id", bus.rsp_id_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b1;

    // Both requesters continuously valid: A first, then alternating.
    drive_req(1'b0, 1'b1, c_sub, 32'd5, 32'd5);
    drive_req(1'b1, 1'b1, c_or, 32'hF0, 32'h0F);
    for (int k = 0; k < 4; k++) begin
      int w = 0;
      @(negedge clk);
      while (!(bus.a_ready_o || bus.b_ready_o) && w < 10) begin
        @(negedge clk);
        w++;
      end
      check_vec("rr_a_ready", bus.a_ready_o, (k % 2 == 0) ? 1 : 0);
      check_vec("rr_b_ready", bus.b_ready_o, (k % 2 == 1) ? 1 : 0);
      @(posedge clk); #1;
      expect_rsp(2, k % 2, (k % 2 == 1) ? 32'hFF : 32'h0, (k % 2 == 1) ? 1'b0 : 1'b1, 1'b0);
    end
    drive_req(1'b0, 1'b0, c_sub, 0, 0);
    drive_req(1'b1, 1'b0, c_or, 0, 0);

    // B multiply wraps to zero; A stalls for the whole operation.
    drive_req(1'b1, 1'b1, c_mul, 32'h10000, 32'h10000);
    @(negedge clk);
    check_vec("mul_grant", bus.b_ready_o, 1);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, c_mul, 0, 0);
    drive_req(1'b0, 1'b1, c_and, 32'hFF, 32'h0F);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_vec("mul_a_stall", bus.a_ready_o, 0);
      check_vec("mul_valid", bus.rsp_valid_o, (c == 4) ? 1 : 0);
      if (c < 4) @(posedge clk);
    end
    check_vec("mul_data", bus.rsp_data_o, 0);
    check_vec("mul_zero", bus.rsp_zero_o, 1);
    check_vec("mul_id", bus.rsp_id_o, 1);
    check_vec("mul_err", bus.rsp_err_o, 0);
    @(posedge clk);
    @(negedge clk);
    check_vec("after_mul_a_ready", bus.a_ready_o, 1);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, c_and, 0, 0);
    expect_rsp(2, 1'b0, 32'h0F, 1'b0, 1'b0);

    // A add overflow, illegal op, then a legal op clears err.
    run_op(1'b0, c_add, 32'h7FFFFFFF, 32'h1, 2, 32'h80000000, 1'b0, 1'b0);
    run_op(1'b0, c_ill, 32'h1234, 32'h5678, 2, 32'h0, 1'b1, 1'b1);
    run_op(1'b1, c_add, 32'd2, 32'd3, 2, 32'd5, 1'b0, 1'b0);

    // Response back-pressure for ten cycles with B pending.
    bus.rsp_ready_i = 1'b0;
    drive_req(1'b0, 1'b1, c_or, 32'h1, 32'h2);
    @(negedge clk);
    check_vec("bp_grant", bus.a_ready_o, 1);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, c_or, 0, 0);
    drive_req(1'b1, 1'b1, c_add, 32'd10, 32'd20);
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_vec("bp_valid", bus.rsp_valid_o, 1);
      check_vec("bp_data", bus.rsp_data_o, 32'h3);
      check_vec("bp_a_ready", bus.a_ready_o, 0);
      check_vec("bp_b_ready", bus.b_ready_o, 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check_vec("bp_hs_valid", bus.rsp_valid_o, 1);
    @(posedge clk);
    @(negedge clk);
    check_vec("bp_b_accept", bus.b_ready_o, 1);
    check_vec("bp_busy", bus.busy_o, 0);
    check_vec("bp_valid_clr", bus.rsp_valid_o, 0);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, c_add, 0, 0);
    expect_rsp(2, 1'b1, 32'd30, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a multiply.
    drive_req(1'b1, 1'b1, c_mul, 32'd7, 32'd9);
    @(negedge clk);
    check_vec("rstmid_grant", bus.b_ready_o, 1);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, c_mul, 0, 0);
    @(negedge clk);
    check_vec("rstmid_busy_pre", bus.busy_o, 1);
    #2 rst_i = 1'b0;
    #1;
    check_vec("rstmid_busy", bus.busy_o, 0);
    check_vec("rstmid_valid", bus.rsp_valid_o, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_i = 1'b1;
    drive_req(1'b0, 1'b1, c_add, 32'd100, 32'd200);
    drive_req(1'b1, 1'b1, c_sub, 32'd1, 32'd2);
    @(negedge clk);
    check_vec("rstmid_a_first", bus.a_ready_o, 1);
    check_vec("rstmid_b_wait", bus.b_ready_o, 0);
    check_vec("rstmid_no_rsp", bus.rsp_valid_o, 0);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, c_add, 0, 0);
    drive_req(1'b1, 1'b0, c_sub, 0, 0);
    expect_rsp(2, 1'b0, 32'd300, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
